// File: rtl/ifetch_unit.sv
// ifetch_unit: PC holder and ROM fetcher with valid/ready output; define IFETCH_PREFETCH_EN for a one-entry sequential prefetch buffer
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_ack,
   output logic [31:0]       instruction,
   output logic [31:0]       opcplus4,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              Branch,
   input  logic              nBranch,
   input  logic              Jmp,
   input  logic              Jal,
   input  logic              Jr,
   input  logic              Zero,
   input  logic [31:0]       Addr_result,
   input  logic [31:0]       Read_data_1
);
   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_HOLD
`ifdef IFETCH_PREFETCH_EN
      , S_DRAIN
`endif
   } state_t;
   state_t      state, state_nxt;
   logic [31:0] pc, next_pc;
   logic        retire, taken, unused;
`ifdef IFETCH_PREFETCH_EN
   logic [31:0] buf_data;
   logic        buf_valid, seq;
   assign seq = (next_pc == opcplus4);
`endif
   assign retire = inst_valid & inst_ready;
   assign taken  = (Branch & Zero) | (nBranch & ~Zero);
   assign unused = ^{Read_data_1[1:0], Addr_result[1:0]};

   // next PC chosen by redirect priority: jr, then j/jal, then taken branch, else sequential
   always_comb begin
      next_pc = Jr ? {Read_data_1[31:2], 2'b00} :
                (Jmp | Jal) ? {opcplus4[31:28], instruction[25:0], 2'b00} :
                taken ? {Addr_result[31:2], 2'b00} : opcplus4;
   end

   // state register
   always_ff @(posedge clk) begin
      state <= rst ? S_ISSUE : state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = imem_ack ? S_HOLD : S_WAIT;
`ifdef IFETCH_PREFETCH_EN
         S_HOLD:  state_nxt = !retire ? S_HOLD :
                              seq ? ((buf_valid | imem_ack) ? S_HOLD : S_WAIT) :
                              (buf_valid | imem_ack) ? S_ISSUE : S_DRAIN;
         S_DRAIN: state_nxt = imem_ack ? S_ISSUE : S_DRAIN;
`else
         S_HOLD:  state_nxt = retire ? S_ISSUE : S_HOLD;
`endif
         default: state_nxt = S_ISSUE;
      endcase
   end

   // ROM request and address; HOLD/DRAIN address the speculative word at opcplus4
   always_comb begin
`ifdef IFETCH_PREFETCH_EN
      imem_req  = ~rst & ((state == S_ISSUE) | (state == S_WAIT) | (state == S_DRAIN) |
                          ((state == S_HOLD) & ~buf_valid));
      imem_addr = (state == S_HOLD || state == S_DRAIN) ? opcplus4[ADDR_W+1:2] : pc[ADDR_W+1:2];
`else
      imem_req  = ~rst & (state != S_HOLD);
      imem_addr = pc[ADDR_W+1:2];
`endif
   end

   // PC, presented instruction and prefetch buffer updates
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         instruction <= '0;
         opcplus4    <= '0;
         inst_valid  <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
         buf_valid   <= 1'b0;
`endif
      end else begin
         if (state == S_WAIT && imem_ack) begin
            instruction <= imem_rdata;
            opcplus4    <= pc + 32'd4;
            inst_valid  <= 1'b1;
         end
`ifdef IFETCH_PREFETCH_EN
         if (state == S_HOLD && !retire && !buf_valid && imem_ack) begin
            buf_data  <= imem_rdata;
            buf_valid <= 1'b1;
         end
         if (retire) begin
            pc        <= next_pc;
            buf_valid <= 1'b0;
            if (seq && (buf_valid || imem_ack)) begin
               instruction <= buf_valid ? buf_data : imem_rdata;
               opcplus4    <= opcplus4 + 32'd4;
            end else begin
               inst_valid <= 1'b0;
            end
         end
`else
         if (retire) begin
            pc         <= next_pc;
            inst_valid <= 1'b0;
         end
`endif
      end
   end
endmodule
